// File: rtl/draw_pkg.sv
// Shared drawing definitions: palette, default screen geometry and painter state encoding.
// Used by the square painter and its offset counter.
package draw_pkg;

   localparam logic [2:0] BLACK  = 3'b000;
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b110;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] BLUE   = 3'b001;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_FIN  = 2'd2
   } painter_state_t;

endpackage

// File: rtl/square_offset_counter.sv
// Row-major dx/dy walker over a SIDE x SIDE square. Presents the offsets of the
// pixel that follows the current one, plus a flag when the current one is the last.
module square_offset_counter
   import draw_pkg::*;
#(
   parameter int SIDE = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clear,
   input  logic                      enable,
   output logic [$clog2(SIDE)-1:0]   nxt_dx,
   output logic [$clog2(SIDE)-1:0]   nxt_dy,
   output logic                      last
);

   localparam int OW = $clog2(SIDE);
   localparam int CW = 2 * OW;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // SIDE is a power of two, so dx is simply the low half of the linear index.
   assign cnt_nxt = cnt + CW'(1);
   assign nxt_dx  = cnt_nxt[OW-1:0];
   assign nxt_dy  = cnt_nxt[CW-1:OW];
   assign last    = &cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/square_pixel_painter.sv
// Rasterises one square request into SIDE*SIDE clipped single-pixel VGA writes,
// one per clock, with a registered valid/ready request port and a done pulse.
module square_pixel_painter
   import draw_pkg::*;
#(
   parameter int SIDE     = 4,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COL_W    = 3,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             abort,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [X_W-1:0]   req_x,
   input  logic [Y_W-1:0]   req_y,
   input  logic [COL_W-1:0] req_colour,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [COL_W-1:0] vga_colour,
   output logic             vga_plot,
   output logic             busy,
   output logic             done
);

   localparam int OW = $clog2(SIDE);
   localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCREEN_H);

   function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
      return (px < SCR_W_L) && (py < SCR_H_L);
   endfunction

   painter_state_t state;

   logic [X_W-1:0]   x0_p0;
   logic [Y_W-1:0]   y0_p0;
   logic [COL_W-1:0] colour_p0;

   logic [X_W-1:0]   vga_x_p1;
   logic [Y_W-1:0]   vga_y_p1;
   logic [COL_W-1:0] vga_colour_p1;
   logic             vld_p1;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;

   logic [OW-1:0]    nxt_dx;
   logic [OW-1:0]    nxt_dy;
   logic             last;
   logic             hs;
   logic             cnt_en;

   logic [X_W-1:0]   base_x;
   logic [Y_W-1:0]   base_y;
   logic [COL_W-1:0] base_colour;
   logic [OW-1:0]    off_x;
   logic [OW-1:0]    off_y;
   logic [X_W:0]     sx;
   logic [Y_W:0]     sy;

   assign hs     = (state == ST_IDLE) && req_valid && ready_q;
   assign cnt_en = (state == ST_DRAW) && !abort && !last;

   square_offset_counter #(
      .SIDE (SIDE)
   ) u_offset (
      .clk    (clk),
      .resetn (resetn),
      .clear  (hs),
      .enable (cnt_en),
      .nxt_dx (nxt_dx),
      .nxt_dy (nxt_dy),
      .last   (last)
   );

   // Pixel 0 is built straight from the request so it appears one cycle after the handshake.
   always_comb begin
      base_x      = x0_p0;
      base_y      = y0_p0;
      base_colour = colour_p0;
      off_x       = nxt_dx;
      off_y       = nxt_dy;
      if (hs) begin
         base_x      = req_x;
         base_y      = req_y;
         base_colour = req_colour;
         off_x       = '0;
         off_y       = '0;
      end
   end

   // Widened sums so a square hanging off the right/bottom edge clips instead of wrapping.
   assign sx = {1'b0, base_x} + {{(X_W+1-OW){1'b0}}, off_x};
   assign sy = {1'b0, base_y} + {{(Y_W+1-OW){1'b0}}, off_y};

   // ---- p0: request latch ----
   always_ff @(posedge clk) begin
      if (hs) begin
         x0_p0     <= req_x;
         y0_p0     <= req_y;
         colour_p0 <= req_colour;
      end
   end

   // ---- p1: FSM and registered pixel outputs ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         vga_x_p1      <= '0;
         vga_y_p1      <= '0;
         vga_colour_p1 <= '0;
         vld_p1        <= 1'b0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               vld_p1 <= 1'b0;
               done_q <= 1'b0;
               if (hs) begin
                  state         <= ST_DRAW;
                  vga_x_p1      <= sx[X_W-1:0];
                  vga_y_p1      <= sy[Y_W-1:0];
                  vga_colour_p1 <= base_colour;
                  vld_p1        <= on_screen(sx, sy);
                  ready_q       <= 1'b0;
                  busy_q        <= 1'b1;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_DRAW: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  vld_p1  <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (last) begin
                  state  <= ST_FIN;
                  vld_p1 <= 1'b0;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  vga_x_p1      <= sx[X_W-1:0];
                  vga_y_p1      <= sy[Y_W-1:0];
                  vga_colour_p1 <= base_colour;
                  vld_p1        <= on_screen(sx, sy);
               end
            end
            ST_FIN: begin
               state   <= ST_IDLE;
               vld_p1  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               vld_p1  <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign vga_x      = vga_x_p1;
   assign vga_y      = vga_y_p1;
   assign vga_colour = vga_colour_p1;
   assign vga_plot   = vld_p1;
   assign req_ready  = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_square_pixel_painter.sv
// Directed bench for square_pixel_painter: single, back-to-back, clipped, aborted,
// reset-interrupted and erase squares against hand-derived pixel sequences.
module tb_square_pixel_painter;
   import draw_pkg::*;

   logic       clk;
   logic       resetn;
   logic       abort;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [2:0] req_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_plots  = 0;
   int n_done   = 0;

   square_pixel_painter dut (
      .clk        (clk),
      .resetn     (resetn),
      .abort      (abort),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request and checks every cycle through done and the return of req_ready.
   // While drawing, the request inputs are moved to (hold, nx) to show they are ignored.
   task automatic run_square(input string tag, input int x, input int y, input int col,
                             input bit hold, input int nx, input int exp_plots);
      int plots;
      int ex;
      int ey;
      plots = 0;
      chk($sformatf("%s_ready_pre", tag), req_ready, 1);
      req_valid  = 1'b1;
      req_x      = 8'(x);
      req_y      = 7'(y);
      req_colour = 3'(col);
      tick();
      req_valid  = hold;
      req_x      = 8'(nx);
      req_colour = ~3'(col);
      for (int k = 0; k < 16; k++) begin
         ex = x + (k % 4);
         ey = y + (k / 4);
         chk($sformatf("%s_px%0d_x", tag, k), vga_x, ex & 255);
         chk($sformatf("%s_px%0d_y", tag, k), vga_y, ey & 127);
         chk($sformatf("%s_px%0d_col", tag, k), vga_colour, col);
         chk($sformatf("%s_px%0d_plot", tag, k), vga_plot, (ex < 160 && ey < 120) ? 1 : 0);
         chk($sformatf("%s_px%0d_busy", tag, k), busy, 1);
         chk($sformatf("%s_px%0d_done", tag, k), done, 0);
         if (vga_plot) begin
            plots++;
            n_plots++;
         end
         tick();
      end
      chk($sformatf("%s_done", tag), done, 1);
      chk($sformatf("%s_fin_plot", tag), vga_plot, 0);
      chk($sformatf("%s_fin_busy", tag), busy, 0);
      chk($sformatf("%s_fin_ready", tag), req_ready, 0);
      if (done) n_done++;
      chk($sformatf("%s_plot_count", tag), plots, exp_plots);
      tick();
      chk($sformatf("%s_ready_post", tag), req_ready, 1);
      chk($sformatf("%s_done_post", tag), done, 0);
      chk($sformatf("%s_plot_post", tag), vga_plot, 0);
   endtask

   initial begin
      int p0;
      int d0;
      resetn     = 1'b0;
      abort      = 1'b0;
      req_valid  = 1'b0;
      req_x      = '0;
      req_y      = '0;
      req_colour = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_col", vga_colour, 0);
      chk("rst_plot", vga_plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      resetn = 1'b1;
      tick();
      chk("rel_ready", req_ready, 1);
      chk("rel_plot", vga_plot, 0);

      // 1: single red square
      run_square("t1", 10, 112, 32'(RED), 1'b0, 0, 16);

      // 2: ten back-to-back squares with req_valid held
      p0 = n_plots;
      d0 = n_done;
      for (int i = 0; i < 10; i++) begin
         run_square($sformatf("t2_%0d", i), 10 + 10 * i, 20, 32'(BLUE),
                    (i < 9), 20 + 10 * i, 16);
      end
      chk("t2_total_plots", n_plots - p0, 160);
      chk("t2_total_done", n_done - d0, 10);

      // 3: clipped in the bottom-right corner
      run_square("t3", 158, 118, 32'(YELLOW), 1'b0, 0, 4);

      // 4: abort after the fifth pixel
      chk("t4_ready_pre", req_ready, 1);
      req_valid  = 1'b1;
      req_x      = 8'd30;
      req_y      = 7'd40;
      req_colour = GREEN;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4_px%0d_x", k), vga_x, 30 + (k % 4));
         chk($sformatf("t4_px%0d_y", k), vga_y, 40 + (k / 4));
         chk($sformatf("t4_px%0d_plot", k), vga_plot, 1);
         if (k < 4) tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_abort_plot", vga_plot, 0);
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_done", done, 0);
      chk("t4_abort_ready", req_ready, 1);
      tick();
      chk("t4_nodone", done, 0);
      chk("t4_idle_plot", vga_plot, 0);
      run_square("t4_next", 0, 0, 32'(BLUE), 1'b0, 0, 16);

      // 5: asynchronous reset at pixel 8
      req_valid  = 1'b1;
      req_x      = 8'd60;
      req_y      = 7'd60;
      req_colour = RED;
      tick();
      req_valid = 1'b0;
      repeat (8) tick();
      chk("t5_px8_x", vga_x, 60);
      chk("t5_px8_y", vga_y, 62);
      chk("t5_px8_plot", vga_plot, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("t5_rst_x", vga_x, 0);
      chk("t5_rst_y", vga_y, 0);
      chk("t5_rst_col", vga_colour, 0);
      chk("t5_rst_plot", vga_plot, 0);
      chk("t5_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();
      chk("t5_rel_ready", req_ready, 1);
      p0 = 0;
      for (int k = 0; k < 20; k++) begin
         if (vga_plot || busy || done) p0++;
         tick();
      end
      chk("t5_quiet_cycles", p0, 0);

      // 6: erase; a different request waiting during DRAW is not taken
      run_square("t6", 50, 112, 32'(BLACK), 1'b1, 90, 16);
      req_valid = 1'b0;
      tick();
      chk("t6_no_hs_busy", busy, 0);
      chk("t6_no_hs_plot", vga_plot, 0);
      chk("t6_no_hs_ready", req_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
